// File: rtl/sfr_scanner.sv
// SFR read initiator: walks responder addresses 0..15, caches every word and decodes version/feature fields.
// Optional version gate on ver_ok is enabled by defining SFR_VERSION_CHECK_EN.
module sfr_scanner #(
    parameter int WIDTH     = 32,
    parameter int RD_LAT    = 0,
    parameter int AUTO_SCAN = 1,
    parameter int MIN_MAIN  = 0,
    parameter int MIN_SUB   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic [3:0]       sfr_addr,
    output logic             sfr_cen,
    input  logic [WIDTH-1:0] sfr_din,
    input  logic [3:0]       rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [7:0]       ver_main,
    output logic [7:0]       ver_sub,
    output logic [7:0]       ver_rel,
    output logic             feat_getb_ext,
    output logic             feat_sfr,
    output logic             feat_flag32,
    output logic             ver_ok
);

    localparam int            CW  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam logic [CW-1:0] LAT = CW'(RD_LAT);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    logic [CW-1:0]    wait_q, wait_d;
    logic             valid_q, valid_d;
    logic             auto_q, auto_d;
    logic             cen_q, cen_d;
    logic [3:0]       addr_q, addr_d;
    logic [WIDTH-1:0] cache_q [16];
    logic [WIDTH-1:0] cache_d [16];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wait_d  = wait_q;
        valid_d = valid_q;
        auto_d  = 1'b0;
        cache_d = cache_q;
        case (state_q)
            IDLE: begin
                if (start || auto_q) begin
                    state_d = READ;
                    idx_d   = 4'd0;
                    wait_d  = '0;
                    valid_d = 1'b0;
                end
            end
            READ: begin
                if (wait_q < LAT) begin
                    wait_d = wait_q + CW'(1);
                end else begin
                    cache_d[idx_q] = sfr_din;
                    wait_d         = '0;
                    idx_d          = idx_q + 4'd1;
                    if (idx_q == 4'd15) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Bus strobes are registered from the next state so they line up with READ exactly.
        cen_d  = (state_d == READ);
        addr_d = cen_d ? idx_d : 4'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            wait_q  <= '0;
            valid_q <= 1'b0;
            auto_q  <= (AUTO_SCAN != 0);
            cen_q   <= 1'b0;
            addr_q  <= 4'd0;
            for (int i = 0; i < 16; i++) begin
                cache_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            valid_q <= valid_d;
            auto_q  <= auto_d;
            cen_q   <= cen_d;
            addr_q  <= addr_d;
            cache_q <= cache_d;
        end
    end

    assign busy          = (state_q == READ);
    assign done          = (state_q == DONE);
    assign valid         = valid_q;
    assign sfr_cen       = cen_q;
    assign sfr_addr      = addr_q;
    assign rd_data       = cache_q[rd_addr];
    assign ver_main      = cache_q[1][23:16];
    assign ver_sub       = cache_q[1][15:8];
    assign ver_rel       = cache_q[1][7:0];
    assign feat_getb_ext = cache_q[2][0];
    assign feat_sfr      = cache_q[2][1];
    assign feat_flag32   = cache_q[2][2];

`ifdef SFR_VERSION_CHECK_EN
    localparam logic [15:0] MIN_VER = {8'(MIN_MAIN), 8'(MIN_SUB)};
    assign ver_ok = valid_q && ({ver_main, ver_sub} >= MIN_VER);
`else
    logic unused_min;
    assign unused_min = ^{MIN_MAIN, MIN_SUB};
    assign ver_ok     = valid_q;
`endif

endmodule

// File: tb/tb_sfr_scanner.sv
// Scoreboard bench for sfr_scanner: two instances (RD_LAT 0 and 2) share stimulus and a queue of expected scans.
module tb_sfr_scanner;

    localparam int SLOW_END = 16 * 3;

    typedef struct packed {
        logic [31:0]       s;
        logic [15:0][31:0] words;
    } scan_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [3:0]        rd_addr;
    logic [15:0][31:0] mem;

    logic        busy_w  [2];
    logic        done_w  [2];
    logic        valid_w [2];
    logic        cen_w   [2];
    logic        ok_w    [2];
    logic        fg_w    [2];
    logic        fs_w    [2];
    logic        ff_w    [2];
    logic [3:0]  addr_w  [2];
    logic [31:0] din_w   [2];
    logic [31:0] rdd_w   [2];
    logic [7:0]  vm_w    [2];
    logic [7:0]  vs_w    [2];
    logic [7:0]  vr_w    [2];

    scan_t             sbq [$];
    logic [15:0][31:0] mcache [2];
    logic              mvalid [2];
    int unsigned       cyc = 0;
    int                n_compared = 0;
    int                n_mismatched = 0;

    assign din_w[0] = mem[addr_w[0]];
    assign din_w[1] = mem[addr_w[1]];

    sfr_scanner #(.WIDTH(32), .RD_LAT(0), .AUTO_SCAN(1), .MIN_MAIN(1), .MIN_SUB(3)) u_lat0 (
        .clk(clk), .reset(reset), .start(start), .busy(busy_w[0]), .done(done_w[0]),
        .valid(valid_w[0]), .sfr_addr(addr_w[0]), .sfr_cen(cen_w[0]), .sfr_din(din_w[0]),
        .rd_addr(rd_addr), .rd_data(rdd_w[0]), .ver_main(vm_w[0]), .ver_sub(vs_w[0]),
        .ver_rel(vr_w[0]), .feat_getb_ext(fg_w[0]), .feat_sfr(fs_w[0]),
        .feat_flag32(ff_w[0]), .ver_ok(ok_w[0])
    );

    sfr_scanner #(.WIDTH(32), .RD_LAT(2), .AUTO_SCAN(1), .MIN_MAIN(1), .MIN_SUB(3)) u_lat2 (
        .clk(clk), .reset(reset), .start(start), .busy(busy_w[1]), .done(done_w[1]),
        .valid(valid_w[1]), .sfr_addr(addr_w[1]), .sfr_cen(cen_w[1]), .sfr_din(din_w[1]),
        .rd_addr(rd_addr), .rd_data(rdd_w[1]), .ver_main(vm_w[1]), .ver_sub(vs_w[1]),
        .ver_rel(vr_w[1]), .feat_getb_ext(fg_w[1]), .feat_sfr(fs_w[1]),
        .feat_flag32(ff_w[1]), .ver_ok(ok_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            rd_addr = 4'($urandom_range(0, 15));
        end
    end

    task automatic checkOutput(input string name, input int d, input logic [31:0] act,
                               input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s dut%0d cyc=%0d actual=0x%08h expected=0x%08h",
                     name, d, cyc, act, exp);
        end
    endtask

    function automatic logic exp_ok(input logic v, input logic [31:0] w);
`ifdef SFR_VERSION_CHECK_EN
        return v && (w[23:8] >= 16'h0103);
`else
        return v;
`endif
    endfunction

    task automatic checkIdle(input int d, input logic [15:0][31:0] c, input logic v);
        logic [31:0] w1, w2;
        w1 = c[1];
        w2 = c[2];
        checkOutput("idle_busy", d, 32'(busy_w[d]), 32'd0);
        checkOutput("idle_done", d, 32'(done_w[d]), 32'd0);
        checkOutput("idle_cen", d, 32'(cen_w[d]), 32'd0);
        checkOutput("idle_addr", d, 32'(addr_w[d]), 32'd0);
        checkOutput("idle_valid", d, 32'(valid_w[d]), 32'(v));
        checkOutput("idle_ver_ok", d, 32'(ok_w[d]), 32'(exp_ok(v, w1)));
        checkOutput("idle_rd_data", d, rdd_w[d], c[rd_addr]);
        checkOutput("idle_version", d, {8'd0, vm_w[d], vs_w[d], vr_w[d]}, {8'd0, w1[23:0]});
        checkOutput("idle_feat", d, {29'd0, ff_w[d], fs_w[d], fg_w[d]}, {29'd0, w2[2:0]});
    endtask

    // Monitor: every scan in the queue dictates when each instance must be busy, which address it drives, and when done fires.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int unsigned lat, n, k;
            logic [31:0] w1, w2;
            lat = 32'(d * 2);
            n   = 16 * (lat + 1);
            if (!reset) begin
                checkIdle(d, '0, 1'b0);
            end else if (sbq.size() != 0 && cyc >= sbq[0].s && cyc - sbq[0].s <= n) begin
                k  = cyc - sbq[0].s;
                w1 = sbq[0].words[1];
                w2 = sbq[0].words[2];
                if (k < n) begin
                    checkOutput("scan_busy", d, 32'(busy_w[d]), 32'd1);
                    checkOutput("scan_done", d, 32'(done_w[d]), 32'd0);
                    checkOutput("scan_cen", d, 32'(cen_w[d]), 32'd1);
                    checkOutput("scan_addr", d, 32'(addr_w[d]), k / (lat + 1));
                    checkOutput("scan_valid", d, 32'(valid_w[d]), 32'd0);
                    checkOutput("scan_ver_ok", d, 32'(ok_w[d]), 32'd0);
                    mvalid[d] = 1'b0;
                end else begin
                    checkOutput("done_pulse", d, 32'(done_w[d]), 32'd1);
                    checkOutput("done_busy", d, 32'(busy_w[d]), 32'd0);
                    checkOutput("done_cen", d, 32'(cen_w[d]), 32'd0);
                    checkOutput("done_addr", d, 32'(addr_w[d]), 32'd0);
                    checkOutput("done_version", d, {8'd0, vm_w[d], vs_w[d], vr_w[d]},
                                {8'd0, w1[23:0]});
                    checkOutput("done_feat", d, {29'd0, ff_w[d], fs_w[d], fg_w[d]},
                                {29'd0, w2[2:0]});
                    checkOutput("done_rd_data", d, rdd_w[d], sbq[0].words[rd_addr]);
                    mcache[d] = sbq[0].words;
                    mvalid[d] = 1'b1;
                end
            end else begin
                checkIdle(d, mcache[d], mvalid[d]);
            end
        end
        if (reset && sbq.size() != 0 && cyc >= sbq[0].s + SLOW_END) begin
            void'(sbq.pop_front());
        end
    end

    task automatic stepClk();
        @(posedge clk);
        #2;
    endtask

    task automatic waitUntil(input int unsigned t);
        while (cyc < t) stepClk();
    endtask

    task automatic pushScan(input int unsigned s);
        scan_t e;
        e.s     = s;
        e.words = mem;
        sbq.push_back(e);
    endtask

    // A start is only accepted when no scan is pending; otherwise both instances must ignore it.
    task automatic issueStart();
        start = 1'b1;
        if (sbq.size() == 0) pushScan(cyc + 1);
        stepClk();
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int budget;
        budget = 300;
        while (sbq.size() != 0 && budget > 0) begin
            stepClk();
            budget--;
        end
        if (sbq.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL idle_timeout cyc=%0d actual=pending expected=idle", cyc);
            sbq.delete();
        end
        stepClk();
    endtask

    task automatic applyStimulus(input logic [31:0] v1, input logic [31:0] v2,
                                 input int busy_at, input int reset_at);
        int unsigned s;
        waitIdle();
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[1] = v1;
        mem[2] = v2;
        issueStart();
        s = cyc;
        if (busy_at >= 0) begin
            waitUntil(s + 32'(busy_at));
            issueStart();
        end
        if (reset_at >= 0) begin
            waitUntil(s + 32'(reset_at));
            reset = 1'b0;
            sbq.delete();
            for (int d = 0; d < 2; d++) begin
                mcache[d] = '0;
                mvalid[d] = 1'b0;
            end
            repeat (3) stepClk();
            reset = 1'b1;
            pushScan(cyc + 1);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            mcache[d] = '0;
            mvalid[d] = 1'b0;
        end
        reset   = 1'b1;
        start   = 1'b0;
        rd_addr = 4'd0;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        mem[1] = 32'h0001_0203;
        mem[2] = 32'h0000_0007;
        #1 reset = 1'b0;
        repeat (3) stepClk();
        reset = 1'b1;
        pushScan(cyc + 1);

        applyStimulus(32'h0001_0203, 32'h0000_0007, 5, -1);
        applyStimulus(32'h0001_0203, 32'h0000_0007, -1, 7);
        applyStimulus(32'h0002_0000, 32'h0000_0005, -1, -1);
        applyStimulus(32'h0001_0200, 32'h0000_0002, 16, -1);
        applyStimulus(32'h0001_0300, 32'h0000_0001, 0, -1);
        repeat (6) begin
            applyStimulus($urandom, $urandom,
                          ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 16)) : -1, -1);
        end
        waitIdle();
        repeat (3) stepClk();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/sfr_scanner.md
Name: sfr_scanner

Overview:
- Initiator side of the SFR read interface: walks SFR addresses 0..15 of an SFR responder, caches every returned word, and decodes version and feature fields.
- Sits beside the CPU core and gives it a stable, registered copy of the SFR space plus decoded flags.
- Scans automatically after reset (optional) and on a start pulse.

Parameters:
- WIDTH, 32, SFR data width (must be >= 24).
- RD_LAT, 0, extra wait cycles between driving sfr_addr/sfr_cen and sampling sfr_din (0 = combinational responder).
- AUTO_SCAN, 1, 1 = start a scan automatically on the first clock after reset release.
- MIN_MAIN, 0, minimum accepted main version; used only with SFR_VERSION_CHECK_EN.
- MIN_SUB, 0, minimum accepted sub version; used only with SFR_VERSION_CHECK_EN.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  scan request pulse.
- busy  output  1  scan in progress.
- done  output  1  one-cycle pulse at scan completion.
- valid  output  1  cache holds a complete scan.
- sfr_addr  output  4  SFR address to responder.
- sfr_cen  output  1  SFR access enable to responder.
- sfr_din  input  WIDTH  read data from responder.
- rd_addr  input  4  cache read address.
- rd_data  output  WIDTH  cache[rd_addr], combinational.
- ver_main  output  8  cache[1][23:16].
- ver_sub  output  8  cache[1][15:8].
- ver_rel  output  8  cache[1][7:0].
- feat_getb_ext  output  1  cache[2] bit0.
- feat_sfr  output  1  cache[2] bit1.
- feat_flag32  output  1  cache[2] bit2.
- ver_ok  output  1  version acceptance flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; idx=0; wait counter=0.
  - All 16 cache entries = 0.
  - busy=0, done=0, valid=0, sfr_cen=0, sfr_addr=0.
  - Decoded outputs are 0 (derived from the cleared cache).
- FSM states: IDLE, READ, DONE.
- IDLE:
  - Enter READ when start=1, or on the first clock after reset release if AUTO_SCAN=1.
  - On entry: idx=0, wait counter=0, valid cleared to 0.
- READ:
  - sfr_cen=1, sfr_addr=idx, busy=1.
  - Each clock in which wait counter < RD_LAT increments the counter.
  - The clock in which wait counter == RD_LAT: cache[idx] <= sfr_din, counter <= 0, idx <= idx+1.
  - When idx==15 is captured, go to DONE.
  - Each entry takes RD_LAT+1 cycles; a full scan takes 16*(RD_LAT+1) cycles.
- DONE (one cycle only):
  - done=1, valid<=1, busy=0, sfr_cen=0; then return to IDLE.
- Registered outputs: sfr_cen and sfr_addr are registered, so sfr_cen=0 and sfr_addr=0 outside READ.
- start handling:
  - start while busy (READ) is ignored; the current scan is not restarted.
  - start in DONE is ignored.
  - start in IDLE with valid=1 triggers a rescan: valid drops on entry to READ; old cache contents remain readable until overwritten.
- rd_data: always returns the cache regardless of valid; readers gate on valid.
- Decoded outputs follow the cache continuously, including partial values mid-scan.
- Reset mid-scan aborts immediately to the reset state; with AUTO_SCAN=1 the scan restarts from idx 0 after release.
- idx is 4 bits and wraps to 0 after 15; no scan starts beyond address 15.

Optional Feature:
- Macro: SFR_VERSION_CHECK_EN.
- Defined: ver_ok = valid && ({ver_main,ver_sub} >= {MIN_MAIN,MIN_SUB}), an unsigned 16-bit compare; ver_rel is ignored.
- Not defined: ver_ok = valid; MIN_MAIN and MIN_SUB are unused.

Test Plan:
- AUTO_SCAN=1, RD_LAT=0, responder returns 0x00010203 at addr 1 and 0x7 at addr 2 -> done pulses exactly 16 cycles after the scan starts; ver_main=1, ver_sub=2, ver_rel=3; all three feat flags =1; valid=1.
- RD_LAT=2 -> sfr_addr holds each value for 3 cycles; a full scan is 48 busy cycles; rd_addr=2 returns 0x00000007.
- start pulsed at scan cycle 5 -> ignored; done occurs at the same cycle as with no pulse; exactly one done pulse.
- reset asserted at scan cycle 7, released 3 cycles later -> all outputs 0 during reset; a new scan starts from addr 0; done arrives 16*(RD_LAT+1) cycles after restart.
- Responder changes addr 1 to 0x00020000, then start in IDLE -> valid=0 during the rescan, then 1; ver_main=2, ver_sub=0.
- SFR_VERSION_CHECK_EN, MIN_MAIN=1, MIN_SUB=3, version 1.2 -> ver_ok=0; version 1.3 -> ver_ok=1; macro undefined -> ver_ok=1 in both cases.
